// File: rtl/router_fsm_if.sv
// Handshake bundle between the router sequencing FSM and the source,
// sync block and register block.
interface router_fsm_if;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       fifo_full;
  logic       fifo_empty_0;
  logic       fifo_empty_1;
  logic       fifo_empty_2;
  logic       soft_reset_0;
  logic       soft_reset_1;
  logic       soft_reset_2;
  logic       busy;
  logic       detect_add;
  logic       write_enb_reg;
  logic       ld_state;
  logic       lfd_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;

  modport slave (
    input  pkt_valid, data_in, parity_done, low_pkt_valid, fifo_full,
           fifo_empty_0, fifo_empty_1, fifo_empty_2,
           soft_reset_0, soft_reset_1, soft_reset_2,
    output busy, detect_add, write_enb_reg, ld_state, lfd_state,
           laf_state, full_state, rst_int_reg
  );

  modport master (
    output pkt_valid, data_in, parity_done, low_pkt_valid, fifo_full,
           fifo_empty_0, fifo_empty_1, fifo_empty_2,
           soft_reset_0, soft_reset_1, soft_reset_2,
    input  busy, detect_add, write_enb_reg, ld_state, lfd_state,
           laf_state, full_state, rst_int_reg
  );
endinterface

// File: rtl/router_fsm.sv
// Sequencing controller for the 1x3 router: header decode, load/full/parity steering.
// Optional completed-packet counter enabled by defining ROUTER_FSM_PKT_CNT_EN.
module router_fsm #(
  parameter int PKT_CNT_W = 8
) (
  input  logic        clock,
  input  logic        resetn,
  router_fsm_if.slave bus
`ifdef ROUTER_FSM_PKT_CNT_EN
  ,
  output logic [PKT_CNT_W-1:0] pkt_cnt
`endif
);

  typedef enum logic [2:0] {
    DA  = 3'd0,
    WTE = 3'd1,
    LFD = 3'd2,
    LD  = 3'd3,
    FFS = 3'd4,
    LAF = 3'd5,
    LP  = 3'd6,
    CPE = 3'd7
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [1:0] addr_q;
  logic       sel_empty;
  logic       sel_soft;
  logic       da_empty;

  // Per-port flags steered by the latched address (after decode) or the live header (in DA).
  always_comb begin
    sel_empty = 1'b0;
    sel_soft  = 1'b0;
    case (addr_q)
      2'b00:   begin sel_empty = bus.fifo_empty_0; sel_soft = bus.soft_reset_0; end
      2'b01:   begin sel_empty = bus.fifo_empty_1; sel_soft = bus.soft_reset_1; end
      2'b10:   begin sel_empty = bus.fifo_empty_2; sel_soft = bus.soft_reset_2; end
      default: begin sel_empty = 1'b0;             sel_soft = 1'b0;             end
    endcase
  end

  always_comb begin
    da_empty = 1'b0;
    case (bus.data_in)
      2'b00:   da_empty = bus.fifo_empty_0;
      2'b01:   da_empty = bus.fifo_empty_1;
      2'b10:   da_empty = bus.fifo_empty_2;
      default: da_empty = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= DA;
      addr_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      if (state_q == DA && bus.pkt_valid && bus.data_in != 2'b11)
        addr_q <= bus.data_in;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DA:  if (bus.pkt_valid && bus.data_in != 2'b11)
             state_d = da_empty ? LFD : WTE;
      WTE: if (sel_empty) state_d = LFD;
      LFD: state_d = LD;
      LD: begin
        if (bus.fifo_full)       state_d = FFS;
        else if (!bus.pkt_valid) state_d = LP;
      end
      FFS: if (!bus.fifo_full) state_d = LAF;
      LAF: begin
        if (bus.parity_done)        state_d = DA;
        else if (bus.low_pkt_valid) state_d = LP;
        else                        state_d = LD;
      end
      LP:  state_d = CPE;
      CPE: state_d = bus.fifo_full ? FFS : DA;
      default: state_d = DA;
    endcase
    // A read-side timeout on the selected port abandons the packet from anywhere but DA.
    if (state_q != DA && sel_soft)
      state_d = DA;
  end

  always_comb begin
    bus.busy          = 1'b0;
    bus.detect_add    = 1'b0;
    bus.write_enb_reg = 1'b0;
    bus.ld_state      = 1'b0;
    bus.lfd_state     = 1'b0;
    bus.laf_state     = 1'b0;
    bus.full_state    = 1'b0;
    bus.rst_int_reg   = 1'b0;
    case (state_q)
      DA:  bus.detect_add = 1'b1;
      WTE: bus.busy = 1'b1;
      LFD: begin bus.busy = 1'b1; bus.lfd_state = 1'b1; bus.write_enb_reg = 1'b1; end
      LD:  begin bus.ld_state = 1'b1; bus.write_enb_reg = 1'b1; end
      FFS: begin bus.busy = 1'b1; bus.full_state = 1'b1; end
      LAF: begin bus.busy = 1'b1; bus.laf_state = 1'b1; bus.write_enb_reg = 1'b1; end
      LP:  begin bus.busy = 1'b1; bus.write_enb_reg = 1'b1; end
      CPE: begin bus.busy = 1'b1; bus.rst_int_reg = 1'b1; end
      default: bus.detect_add = 1'b1;
    endcase
  end

`ifdef ROUTER_FSM_PKT_CNT_EN
  logic pkt_done;

  // Only normal completions count; soft-reset exits are excluded.
  assign pkt_done = !sel_soft &&
                    ((state_q == CPE && !bus.fifo_full) ||
                     (state_q == LAF && bus.parity_done));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)       pkt_cnt <= '0;
    else if (pkt_done) pkt_cnt <= pkt_cnt + 1'b1;
  end
`else
  if (PKT_CNT_W < 1) begin : g_unused_cnt_w
  end
`endif

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Sequencing controller for the 1x3 router datapath: decodes the header address, steers the register block and the sync block, and throttles the source through busy.
- Consumes the sync block's fifo_full, soft_reset_k and the FIFO empty flags, and the register block's parity_done and low_pkt_valid.
- Drives detect_add and write_enb_reg into the sync block, and lfd/ld/laf/full/rst_int strobes into the register block.

Parameters:
PKT_CNT_W, 8, width of the optional completed-packet counter (used only with ROUTER_FSM_PKT_CNT_EN).

Ports:
clock  input  1  system clock; all state changes on the rising edge
resetn  input  1  asynchronous active-low reset
pkt_valid  input  1  source packet valid
data_in  input  2  header address bits [1:0] of the current source byte
parity_done  input  1  register block has captured the parity byte
low_pkt_valid  input  1  register block saw pkt_valid drop while in full handling
fifo_full  input  1  selected FIFO full (from sync block)
fifo_empty_0/1/2  input  1 each  FIFO k empty
soft_reset_0/1/2  input  1 each  FIFO k soft reset (read-side timeout)
busy  output  1  source must hold the current byte
detect_add  output  1  header-decode window; sync block latches the address
write_enb_reg  output  1  write permitted into the selected FIFO
ld_state  output  1  payload load
lfd_state  output  1  first byte (header) load
laf_state  output  1  load-after-full
full_state  output  1  stalled on full FIFO
rst_int_reg  output  1  clear register-block internal parity/data regs
pkt_cnt  output  PKT_CNT_W  completed packets (only with ROUTER_FSM_PKT_CNT_EN)

Behaviour:
- States: DA (decode_address), WTE (wait_till_empty), LFD (load_first_data), LD (load_data), FFS (fifo_full_state), LAF (load_after_full), LP (load_parity), CPE (check_parity_error).
- Outputs are Moore, decoded from the state register only; no output depends combinationally on inputs.
- Reset (resetn=0, asynchronous): state=DA; addr_q=2'b00; pkt_cnt=0.
- Output values on reset equal the DA decode: detect_add=1, all other outputs 0.
- addr_q: 2-bit register, loaded with data_in when state=DA && pkt_valid && data_in!=2'b11; otherwise holds. sel_empty = fifo_empty_[addr_q].
- In DA, the address decode uses data_in directly, not addr_q.
- DA: detect_add=1, busy=0.
  - pkt_valid && data_in==k && fifo_empty_k -> LFD.
  - pkt_valid && data_in==k && !fifo_empty_k -> WTE.
  - data_in==3 or !pkt_valid -> stay.
- WTE: busy=1. sel_empty -> LFD; else stay.
- LFD: busy=1, lfd_state=1, write_enb_reg=1. Always -> LD (exactly one cycle).
- LD: busy=0, ld_state=1, write_enb_reg=1. Transition priority:
  - fifo_full -> FFS.
  - else !pkt_valid -> LP.
  - else stay.
- FFS: busy=1, full_state=1, write_enb_reg=0. !fifo_full -> LAF; else stay.
- LAF: busy=1, laf_state=1, write_enb_reg=1. Transition priority:
  - parity_done -> DA.
  - else low_pkt_valid -> LP.
  - else -> LD.
- LP: busy=1, write_enb_reg=1. Always -> CPE.
- CPE: busy=1, rst_int_reg=1, write_enb_reg=0. fifo_full -> FFS; else -> DA.
- Soft reset: soft_reset_[addr_q]=1 in any state other than DA forces next state=DA.
  - Highest priority over all other transitions.
  - soft_reset of a non-selected port is ignored. In DA, soft resets have no effect.
- Latency: header accepted in DA to first LD cycle = 2 clocks when the target FIFO is empty.
- Illegal encodings (unused state codes) -> DA on next edge.
- Reset asserted mid-packet: immediate return to DA and all strobes low, regardless of clock.

Optional Feature:
- Macro: ROUTER_FSM_PKT_CNT_EN.
- Defined:
  - pkt_cnt port exists; increments by 1 on each CPE->DA or LAF->DA transition.
  - Wraps modulo 2^PKT_CNT_W; not incremented on soft-reset exits.
  - Reset value 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset during LD (resetn low at mid-cycle) -> state DA within the same cycle, detect_add=1, busy=0, write_enb_reg=0, no clock needed.
- Normal packet, data_in=2'b01, fifo_empty_1=1, pkt_valid high 5 clocks then low, fifo_full=0 -> sequence DA,LFD,LD,...,LP,CPE,DA. lfd_state high exactly 1 cycle; rst_int_reg high 1 cycle; pkt_cnt 0->1 with macro.
- data_in=2'b10, fifo_empty_2=0 for 4 clocks then 1 -> WTE held 4 cycles with busy=1, then LFD. addr_q=2 retained throughout.
- In LD, fifo_full=1 for 3 clocks -> FFS 3 cycles (write_enb_reg=0, busy=1), then LAF. With low_pkt_valid=1, parity_done=0 -> LP next. With parity_done=1 instead -> DA.
- Packet to port 0 in LD; soft_reset_1=1 -> no effect. Then soft_reset_0=1 -> DA next edge; pkt_cnt unchanged.
- data_in=2'b11 with pkt_valid=1 for 3 clocks -> stays DA, addr_q unchanged. Then 256 packets with PKT_CNT_W=8 -> pkt_cnt wraps to 0.
